// File: rtl/xtop_w_pkg.sv
// Shared definitions for the xtop_w memory game: FSM encoding, LFSR taps and
// the 7-segment lookup.
package xtop_w_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_SHOW  = 3'd2,
    ST_INPUT = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

  // Feedback taps at bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Active-low {dp,g,f,e,d,c,b,a}; dp always off
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] r;
    case (d)
      4'd0:    r = 8'hC0;
      4'd1:    r = 8'hF9;
      4'd2:    r = 8'hA4;
      4'd3:    r = 8'hB0;
      4'd4:    r = 8'h99;
      4'd5:    r = 8'h92;
      4'd6:    r = 8'h82;
      4'd7:    r = 8'hF8;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h90;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xtop_w_disp.sv
// Four-digit multiplexed score display: digit0 units, digit1 tens, digits 2/3
// blank. Output is all-ones (dark) while en is low.
module xtop_w_disp
  import xtop_w_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  score,
  output logic [11:0] seg
);

  logic [SCAN_DIV+1:0] scan_r;
  logic [1:0]          digit_s;
  logic [3:0]          tens_s;
  logic [3:0]          units_s;
  logic [11:0]         seg_s;
  logic [11:0]         seg_r;

  assign digit_s = scan_r[SCAN_DIV+1:SCAN_DIV];

  // Scan counter and registered segment/enable drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_r <= '0;
      seg_r  <= 12'hFFF;
    end else begin
      scan_r <= scan_r + 1'b1;
      seg_r  <= seg_s;
    end
  end

  // Score fits in 0..15, so the tens digit is only ever 0 or 1
  always_comb begin
    tens_s  = 4'd0;
    units_s = score;
    seg_s   = 12'hFFF;
    if (score >= 4'd10) begin
      tens_s  = 4'd1;
      units_s = score - 4'd10;
    end else begin
      tens_s  = 4'd0;
      units_s = score;
    end
    if (en) begin
      case (digit_s)
        2'd0:    seg_s = {4'b1110, seg7(units_s)};
        2'd1:    seg_s = {4'b1101, seg7(tens_s)};
        default: seg_s = 12'hFFF;
      endcase
    end else begin
      seg_s = 12'hFFF;
    end
  end

  assign seg = seg_r;

endmodule

// File: rtl/xtop_w.sv
// Simon-style memory game top. Optional button debounce is enabled by
// defining XTOP_W_DEBOUNCE_EN.
module xtop_w
  import xtop_w_pkg::*;
#(
  parameter int SHOW_CYCLES = 16,
  parameter int MAX_LEN     = 15,
  parameter int SCAN_DIV    = 4,
  parameter int DEB_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic [6:0]  sw,
  output logic [7:0]  leds,
  output logic [11:0] seg,
  output logic        trap
);

  localparam int TW = $clog2(2 * SHOW_CYCLES);

  state_t         state_r, state_n;
  logic [3:0]     sync1_r, sync2_r, btn_q_s, prev_r;
  logic           press_s, valid_s;
  logic [7:0]     lfsr_r, lfsr_nx_s;
  logic [3:0]     gen_cnt_r, l_r, idx_r, echo_r, score_s;
  logic [TW-1:0]  timer_r;
  logic [1:0]     seq_r [16];
  logic [1:0]     seq_cur_s;
  logic [7:0]     leds_s, leds_r;
  logic           trap_r;

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

`ifdef XTOP_W_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [3:0]    deb_r;
  logic [DW-1:0] deb_cnt_r [4];

  // Accept a new level only after it differs from the current one for DEB_CYCLES cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_r <= 4'd0;
      for (int i = 0; i < 4; i++) deb_cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_cnt_r[i] == DW'(DEB_CYCLES - 1)) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= '0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
        end
      end
    end
  end
  assign btn_q_s = deb_r;
`else
  logic unused_deb_s;
  assign unused_deb_s = (DEB_CYCLES > 0);
  assign btn_q_s      = sync2_r;
`endif

  assign press_s   = |(btn_q_s & ~prev_r);
  assign seq_cur_s = seq_r[idx_r];
  assign valid_s   = (btn_q_s == (4'b0001 << seq_cur_s));
  assign lfsr_nx_s = lfsr_step(lfsr_r);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_n;
  end

  // FSM next-state logic; WIN and LOSE only leave via reset
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:  if (press_s) state_n = ST_GEN; else state_n = ST_IDLE;
      ST_GEN:   if (gen_cnt_r == 4'(MAX_LEN - 1)) state_n = ST_SHOW; else state_n = ST_GEN;
      ST_SHOW: begin
        if (timer_r == TW'(2 * SHOW_CYCLES - 1) && idx_r == l_r - 4'd1) state_n = ST_INPUT;
        else state_n = ST_SHOW;
      end
      ST_INPUT: begin
        if (idx_r == l_r)  state_n = (l_r == 4'(MAX_LEN)) ? ST_WIN : ST_SHOW;
        else if (press_s)  state_n = valid_s ? ST_INPUT : ST_LOSE;
        else               state_n = ST_INPUT;
      end
      ST_WIN:   state_n = ST_WIN;
      ST_LOSE:  state_n = ST_LOSE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // FSM output decode (registered below)
  always_comb begin
    leds_s = {l_r, 4'd0};
    case (state_r)
      ST_IDLE:  leds_s = 8'd0;
      ST_SHOW: begin
        if (timer_r < TW'(SHOW_CYCLES)) leds_s = {l_r, 4'b0001 << seq_cur_s};
        else                            leds_s = {l_r, 4'd0};
      end
      ST_INPUT: leds_s = {l_r, echo_r};
      ST_WIN:   leds_s = {l_r, 4'hF};
      default:  leds_s = {l_r, 4'd0};
    endcase
  end

  // Game datapath: LFSR, sequence memory, round length, index and playback timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r    <= 4'd0;
      lfsr_r    <= 8'd0;
      gen_cnt_r <= 4'd0;
      l_r       <= 4'd0;
      idx_r     <= 4'd0;
      timer_r   <= '0;
      echo_r    <= 4'd0;
      leds_r    <= 8'd0;
      trap_r    <= 1'b0;
      for (int i = 0; i < 16; i++) seq_r[i] <= 2'd0;
    end else begin
      prev_r <= btn_q_s;
      leds_r <= leds_s;
      trap_r <= (state_n == ST_WIN) || (state_n == ST_LOSE);
      case (state_r)
        ST_IDLE: begin
          if (press_s) begin
            lfsr_r    <= {1'b1, sw};
            gen_cnt_r <= 4'd0;
          end
        end
        ST_GEN: begin
          lfsr_r           <= lfsr_nx_s;
          seq_r[gen_cnt_r] <= lfsr_nx_s[1:0];
          gen_cnt_r        <= gen_cnt_r + 4'd1;
          if (gen_cnt_r == 4'(MAX_LEN - 1)) begin
            l_r     <= 4'd1;
            idx_r   <= 4'd0;
            timer_r <= '0;
          end
        end
        ST_SHOW: begin
          if (timer_r == TW'(2 * SHOW_CYCLES - 1)) begin
            timer_r <= '0;
            if (idx_r == l_r - 4'd1) idx_r <= 4'd0;
            else                     idx_r <= idx_r + 4'd1;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        ST_INPUT: begin
          if (idx_r == l_r) begin
            if (l_r != 4'(MAX_LEN)) begin
              l_r     <= l_r + 4'd1;
              idx_r   <= 4'd0;
              timer_r <= '0;
              echo_r  <= 4'd0;
            end
          end else if (press_s && valid_s) begin
            idx_r  <= idx_r + 4'd1;
            echo_r <= btn_q_s;
          end else if ((btn_q_s & echo_r) == 4'd0) begin
            echo_r <= 4'd0;
          end
        end
        default: begin
          echo_r <= 4'd0;
        end
      endcase
    end
  end

  // Completed rounds; IDLE/GEN have L=0 and show 0
  always_comb begin
    if (state_r == ST_WIN)  score_s = 4'(MAX_LEN);
    else if (l_r == 4'd0)   score_s = 4'd0;
    else                    score_s = l_r - 4'd1;
  end

  xtop_w_disp #(.SCAN_DIV(SCAN_DIV)) u_disp (
    .clk   (clk),
    .rst   (rst),
    .en    (state_r != ST_IDLE),
    .score (score_s),
    .seg   (seg)
  );

  assign leds = leds_r;
  assign trap = trap_r;

endmodule

// File: tb/tb_xtop_w.sv
// Directed self-checking bench for xtop_w (seed sw=0 throughout).
module tb_xtop_w;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic [6:0]  sw;
  logic [7:0]  leds;
  logic [11:0] seg;
  logic        trap;

  int errors = 0;
  int checks = 0;

  localparam int HOLD = 12;
  // Hand-stepped LFSR from 8'h80: s[1:0] after each of 15 steps
  logic [1:0] exp_seq [15] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd3, 2'd2,
                               2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

  xtop_w dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .leds (leds),
    .seg  (seg),
    .trap (trap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    btn = v;
    cyc(HOLD);
    btn = 4'd0;
    cyc(HOLD);
  endtask

  task automatic wait_digit(input logic [3:0] en_mask, output logic [7:0] segs, output bit ok);
    ok = 1'b0;
    segs = 8'hFF;
    for (int i = 0; i < 300 && !ok; i++) begin
      cyc(1);
      if (seg[11:8] == en_mask) begin
        ok = 1'b1;
        segs = seg[7:0];
      end
    end
  endtask

  task automatic start_game();
    rst = 1'b0;
    btn = 4'd0;
    sw  = 7'h00;
    cyc(3);
    rst = 1'b1;
    cyc(3);
    btn = 4'b0001;
    cyc(3);
    btn = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn = 4'd0;
    sw  = 7'h00;
    cyc(3);
    checks++; if (leds !== 8'h00)   begin errors++; $display("FAIL reset_leds got=%h exp=00", leds); end
    checks++; if (seg !== 12'hFFF)  begin errors++; $display("FAIL reset_seg got=%h exp=fff", seg); end
    checks++; if (trap !== 1'b0)    begin errors++; $display("FAIL reset_trap got=%b exp=0", trap); end
    rst = 1'b1;
    cyc(100);
    checks++; if (leds !== 8'h00)   begin errors++; $display("FAIL idle_leds got=%h exp=00", leds); end
    checks++; if (seg !== 12'hFFF)  begin errors++; $display("FAIL idle_seg got=%h exp=fff", seg); end
    checks++; if (trap !== 1'b0)    begin errors++; $display("FAIL idle_trap got=%b exp=0", trap); end
  endtask

  task automatic test_show();
    int n;
    bit seen;
    start_game();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc(1);
      if (leds == 8'h12) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL show_first got=%h exp=12 (timeout)", leds); end
    n = 0;
    while (leds == 8'h12 && n < 100) begin
      n++;
      cyc(1);
    end
    checks++; if (n != 16)         begin errors++; $display("FAIL show_len got=%0d exp=16", n); end
    checks++; if (leds !== 8'h10)  begin errors++; $display("FAIL show_blank got=%h exp=10", leds); end
    checks++; if (trap !== 1'b0)   begin errors++; $display("FAIL show_trap got=%b exp=0", trap); end
  endtask

  task automatic test_round2();
    logic [7:0] s;
    bit ok;
    cyc(40);
    press(4'b0010);
    checks++; if (leds[7:4] !== 4'h2) begin errors++; $display("FAIL r2_len got=%h exp=2", leds[7:4]); end
    wait_digit(4'b1110, s, ok);
    checks++; if (!ok || s !== 8'hF9) begin errors++; $display("FAIL r2_units got=%h exp=f9", s); end
    wait_digit(4'b1101, s, ok);
    checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL r2_tens got=%h exp=c0", s); end
    cyc(2 * 32 + 20);
    btn = 4'b0010;
    cyc(8);
    checks++; if (leds !== 8'h22) begin errors++; $display("FAIL r2_echo got=%h exp=22", leds); end
    btn = 4'd0;
    cyc(HOLD);
    press(4'b0100);
    checks++; if (leds[7:4] !== 4'h3) begin errors++; $display("FAIL r3_len got=%h exp=3", leds[7:4]); end
  endtask

  task automatic test_lose_wrong();
    logic [7:0] s;
    bit ok;
    start_game();
    cyc(100);
    press(4'b1000);
    checks++; if (trap !== 1'b1)   begin errors++; $display("FAIL lose_trap got=%b exp=1", trap); end
    checks++; if (leds !== 8'h10)  begin errors++; $display("FAIL lose_leds got=%h exp=10", leds); end
    wait_digit(4'b1110, s, ok);
    checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL lose_score got=%h exp=c0", s); end
    cyc(50);
    checks++; if (trap !== 1'b1)   begin errors++; $display("FAIL lose_hold got=%b exp=1", trap); end
  endtask

  task automatic test_lose_multi();
    start_game();
    cyc(100);
    press(4'b0011);
    checks++; if (trap !== 1'b1)   begin errors++; $display("FAIL multi_trap got=%b exp=1", trap); end
    checks++; if (leds !== 8'h10)  begin errors++; $display("FAIL multi_leds got=%h exp=10", leds); end
  endtask

  task automatic test_win();
    logic [7:0] s;
    bit ok;
    start_game();
    cyc(30);
    for (int r = 1; r <= 15; r++) begin
      cyc(r * 32 + 20);
`ifdef XTOP_W_DEBOUNCE_EN
      if (r == 15) begin
        btn = 4'b1000;
        cyc(2);
        btn = 4'd0;
        cyc(10);
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL glitch_trap got=%b exp=0", trap); end
      end
`endif
      if (r == 15) begin
        checks++; if (leds[7:4] !== 4'hF || trap !== 1'b0) begin
          errors++; $display("FAIL pre_win got=%h/%b exp=f/0", leds[7:4], trap);
        end
      end
      for (int j = 0; j < r; j++) press(4'b0001 << exp_seq[j]);
    end
    checks++; if (trap !== 1'b1)   begin errors++; $display("FAIL win_trap got=%b exp=1", trap); end
    checks++; if (leds !== 8'hFF)  begin errors++; $display("FAIL win_leds got=%h exp=ff", leds); end
    wait_digit(4'b1110, s, ok);
    checks++; if (!ok || s !== 8'h92) begin errors++; $display("FAIL win_units got=%h exp=92", s); end
    wait_digit(4'b1101, s, ok);
    checks++; if (!ok || s !== 8'hF9) begin errors++; $display("FAIL win_tens got=%h exp=f9", s); end
  endtask

  initial begin
    rst = 1'b0;
    btn = 4'd0;
    sw  = 7'h00;
    test_reset();
    test_show();
    test_round2();
    test_lose_wrong();
    test_lose_multi();
    test_win();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xtop_w.md
XTOP_W -- requirements
Module: xtop_w

Interface
REQ-001 SHOW_CYCLES, 16, clock cycles each sequence LED is lit and then blanked during playback.
REQ-002 MAX_LEN, 15, number of rounds needed to win (1..15).
REQ-003 SCAN_DIV, 4, display digit advances every 2^SCAN_DIV cycles.
REQ-004 DEB_CYCLES, 4, cycles a button must be stable before it is accepted (debouncer only).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 btn  input  4  player buttons, active-high, asynchronous; the block SHALL double-flop synchronize them.
REQ-008 sw  input  7  LFSR seed, sampled when a game starts.
REQ-009 leds  output  8  [3:0] one-hot sequence/echo LED; [7:4] current round length L.
REQ-010 seg  output  12  [11:8] active-low digit enables (digit3..digit0); [7:0] active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 trap  output  1  game ended (win or lose), held until reset.

Function
REQ-012 FSM states SHALL be IDLE, GEN, SHOW, INPUT, WIN and LOSE.
REQ-013 In IDLE, a rising edge on any btn bit SHALL latch {1'b1,sw} into an 8-bit LFSR and go to GEN.
REQ-014 The LFSR SHALL shift left each step: s <= {s[6:0], s[7]^s[5]^s[4]^s[3]}.
REQ-015 GEN SHALL run MAX_LEN cycles; each cycle steps the LFSR once and stores the new s[1:0] into seq[i], i=0..MAX_LEN-1.
REQ-016 After GEN, L SHALL be 1 and the FSM SHALL enter SHOW.
REQ-017 SHOW SHALL play seq[0..L-1]: for each entry, leds[3:0] is one-hot for SHOW_CYCLES cycles, then 0 for SHOW_CYCLES cycles; after the last entry, idx is 0 and the FSM enters INPUT.
REQ-018 Button edges SHALL be ignored in every state except IDLE and INPUT.
REQ-019 In INPUT, a press is a rising edge of the debounced/synchronized btn vector.
REQ-020 A one-hot press matching seq[idx] SHALL increment idx and echo that button on leds[3:0] while it is held.
REQ-021 A non-one-hot press, or a press not matching seq[idx], SHALL go to LOSE.
REQ-022 When idx reaches L: if L==MAX_LEN, go to WIN; otherwise L<=L+1 and go to SHOW.
REQ-023 WIN and LOSE SHALL be terminal until reset, with trap=1 from the cycle of entry.
REQ-024 In WIN, leds[3:0]=4'hF; in LOSE, leds[3:0]=0.
REQ-025 leds[7:4] SHALL equal L[3:0] in all states, and 0 in IDLE.
REQ-026 Score SHALL be the number of completed rounds: L-1, or MAX_LEN in WIN.
REQ-027 digit1/digit0 SHALL show the score's tens/units in decimal with dp off; digit2 and digit3 SHALL be blank (enable high).
REQ-028 Digits SHALL scan 0->1->2->3->0; exactly one enable is low at a time, except that a blank digit has all enables high.
REQ-029 Segment encoding SHALL be standard; e.g. 0 = 8'hC0, 1 = 8'hF9.

Reset
REQ-030 While rst=0 the block SHALL be in IDLE with L=0, idx=0, leds=0, seg=12'hFFF, trap=0 and seq cleared.
REQ-031 Deasserting reset mid-game SHALL restart from IDLE.

Configuration
REQ-032 With XTOP_W_DEBOUNCE_EN defined, each synchronized button SHALL pass a DEB_CYCLES stability counter before edge detection.
REQ-033 Without XTOP_W_DEBOUNCE_EN, edge detection SHALL use the synchronizer output directly, with 2 cycles of latency.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the LFSR tap constant and the 7-segment lookup table.
REQ-035 The 4-digit scan/decode logic SHALL be one sub-module, xtop_w_disp.

Verification
REQ-036 rst low, then high: leds=0, seg=12'hFFF and trap=0 until a button is pressed.
REQ-037 sw=7'h00, press btn[0]: seq begins 1,2,0 (LFSR states 8'h01, 8'h02, 8'h04); the first SHOW lights leds=8'h12 for SHOW_CYCLES cycles.
REQ-038 Same seed, press btn[1] in INPUT: round 2 starts, with leds[7:4]=2 and display units digit "1" (8'hF9).
REQ-039 Same seed, press btn[3] in INPUT: LOSE, trap=1 on the next cycle, leds[3:0]=0, and the score stays 0.
REQ-040 Press btn=4'b0011 simultaneously in INPUT: LOSE.
REQ-041 Play all MAX_LEN rounds correctly: WIN, trap=1, leds[3:0]=4'hF and display "15"; with debounce enabled, a 2-cycle glitch is ignored.
